// File: rtl/datamem_pkg.sv
// Purpose  : shared encodings, FSM state type and address default for the data-memory responder.
// Latency  : n/a (types, constants and one pure helper function only).
// Backpress: n/a.
// Contents : SZ_* access-size codes, state_t, DEFAULT_BASE_ADDR, is_misaligned().
package datamem_pkg;

  // Access size encodings carried on iSize.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte address of RAM word 0 unless overridden.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Natural alignment check; bytes are always aligned, illegal size is
  // reported separately by the caller.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF) bad = lo[0];
    if (size == SZ_WORD) bad = (lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/datamem_lane_align.sv
// Purpose  : byte-lane steering for the data RAM: store byte-enables/merge and load select/extend.
// Latency  : purely combinational, zero cycles.
// Backpress: none; no handshake, outputs follow inputs.
// Ports    : i_size/i_addr_lo/i_unsigned describe the access, i_wdata is right-aligned store data,
//            i_mem_word is the current RAM word; o_be lanes written, o_wr_word merged word,
//            o_rd_word right-aligned extended load data.
module datamem_lane_align
  import datamem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_rd_word
);

  logic [31:0] w_lanes;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext_b;
  logic        w_sext_h;

  // Replicate narrow store data across all lanes so the enable mask alone
  // picks the destination; avoids a separate shifter.
  always_comb begin
    o_be    = 4'b0000;
    w_lanes = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        w_lanes = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_be    = 4'b1111;
        w_lanes = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        w_lanes = i_wdata;
      end
    endcase
  end

  always_comb begin
    o_wr_word = i_mem_word;
    for (int b = 0; b < 4; b++) begin
      if (o_be[b]) o_wr_word[8*b +: 8] = w_lanes[8*b +: 8];
    end
  end

  always_comb begin
    w_byte = i_mem_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_mem_word[7:0];
      2'd1:    w_byte = i_mem_word[15:8];
      2'd2:    w_byte = i_mem_word[23:16];
      default: w_byte = i_mem_word[31:24];
    endcase
  end

  assign w_half   = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];
  assign w_sext_b = ~i_unsigned & w_byte[7];
  assign w_sext_h = ~i_unsigned & w_half[15];

  always_comb begin
    o_rd_word = 32'd0;
    case (i_size)
      SZ_BYTE: o_rd_word = {{24{w_sext_b}}, w_byte};
      SZ_HALF: o_rd_word = {{16{w_sext_h}}, w_half};
      SZ_WORD: o_rd_word = i_mem_word;
      default: o_rd_word = 32'd0;
    endcase
  end

endmodule

// File: rtl/datamem_responder.sv
// Purpose  : single-outstanding data-memory responder for the MEM stage with an internal word RAM.
// Latency  : legal access responds WAIT_STATES+1 cycles after accept (counting the accept cycle); errors in 1.
// Backpress: oReady only in IDLE; a request while busy is dropped, not queued.
// Ports    : iCLK/iRST_n clock and async active-low reset; iReq/iWe/iAddr/iWData/iSize/iUnsigned request;
//            oReady accept, oRValid one-cycle response strobe, oRData load data, oErr rejected access.
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic [1:0]  iSize,
  input  logic        iUnsigned,
  output logic        oReady,
  output logic        oRValid,
  output logic [31:0] oRData,
  output logic        oErr
);

  localparam int          AW           = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LP_SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [2:0]  LP_WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic        w_enter_resp;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_in_idle;
  logic        w_accept;
  logic        w_e_we;
  logic [31:0] w_e_addr;
  logic [31:0] w_e_wdata;
  logic [1:0]  w_e_size;
  logic        w_e_unsigned;
  logic [31:0] w_off;
  logic [AW-1:0] w_idx;
  logic        w_err;
  logic        w_wr_en;
  logic [31:0] w_mem_word;
  logic [3:0]  w_be;
  logic [31:0] w_wr_word;
  logic [31:0] w_rd_word;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = iReq & w_in_idle;

  // The edge entering RESP can be the accept edge itself (errors, zero wait
  // states), so the request is taken straight from the ports in IDLE and
  // from the latched copy otherwise.
  assign w_e_we       = w_in_idle ? iWe       : r_we;
  assign w_e_addr     = w_in_idle ? iAddr     : r_addr;
  assign w_e_wdata    = w_in_idle ? iWData    : r_wdata;
  assign w_e_size     = w_in_idle ? iSize     : r_size;
  assign w_e_unsigned = w_in_idle ? iUnsigned : r_unsigned;

  // Unsigned wraparound makes addresses below BASE_ADDR land far out of range.
  assign w_off = w_e_addr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];
  assign w_err = (w_e_size == SZ_ILL) | is_misaligned(w_e_size, w_e_addr[1:0]) | (w_off >= LP_SPAN);

  assign w_mem_word = r_mem[w_idx];

  datamem_lane_align u_lane_align (
    .i_size     (w_e_size),
    .i_addr_lo  (w_e_addr[1:0]),
    .i_unsigned (w_e_unsigned),
    .i_wdata    (w_e_wdata),
    .i_mem_word (w_mem_word),
    .o_be       (w_be),
    .o_wr_word  (w_wr_word),
    .o_rd_word  (w_rd_word)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iReq) begin
          if (w_err || (WAIT_STATES == 0)) begin
            w_state_next = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = LP_WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_next = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we       <= iWe;
        r_addr     <= iAddr;
        r_wdata    <= iWData;
        r_size     <= iSize;
        r_unsigned <= iUnsigned;
      end
      // Response registers only move on entry to RESP so they hold otherwise.
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_e_we) ? 32'd0 : w_rd_word;
      end
    end
  end

  // RAM is never reset; the iRST_n term stops a write slipping through while
  // reset is held with iReq high.
  assign w_wr_en = iRST_n & w_enter_resp & ~w_err & w_e_we & (w_be != 4'b0000);

  always_ff @(posedge iCLK) begin
    if (w_wr_en) r_mem[w_idx] <= w_wr_word;
  end

  assign oReady  = w_in_idle;
  assign oRValid = (r_state == ST_RESP);
  assign oRData  = r_rdata;
  assign oErr    = r_err;

endmodule

// File: tb/tb_datamem_responder.sv
`timescale 1ns/1ps
module tb_datamem_responder;
  import datamem_pkg::*;

  localparam logic [31:0] B = 32'h1001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst_n, req, we, uns;
  logic [3:0][31:0] addr, wdata;
  logic [3:0][1:0]  size;
  logic [3:0]       ready, rvalid, err;
  logic [3:0][31:0] rdata;

  // Four instances cover WAIT_STATES = 1, 2, 3, 0 respectively.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    datamem_responder #(
      .DEPTH_WORDS (256),
      .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 0),
      .BASE_ADDR   (32'h1001_0000)
    ) u_dut (
      .iCLK      (clk),
      .iRST_n    (rst_n[g]),
      .iReq      (req[g]),
      .iWe       (we[g]),
      .iAddr     (addr[g]),
      .iWData    (wdata[g]),
      .iSize     (size[g]),
      .iUnsigned (uns[g]),
      .oReady    (ready[g]),
      .oRValid   (rvalid[g]),
      .oRData    (rdata[g]),
      .oErr      (err[g])
    );
  end

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  dut;
    logic        err;
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  string       dq_nm[$];
  logic [31:0] dq_act[$];
  logic [31:0] dq_exp[$];

  int checks = 0;
  int failures = 0;

  exp_t        mon_e;
  string       mon_nm;
  logic [31:0] mon_act, mon_exp;

  // Monitor: sole owner of the counters. Pops direct checks queued by the
  // stimulus and compares every response strobe against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      while (dq_nm.size() != 0) begin
        mon_nm  = dq_nm.pop_front();
        mon_act = dq_act.pop_front();
        mon_exp = dq_exp.pop_front();
        checks++;
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL %s: got %h, expected %h", mon_nm, mon_act, mon_exp);
        end
      end
      for (int d = 0; d < 4; d++) begin
        if (rvalid[d] === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rvalid dut%0d: got data=%h err=%b, expected no response", d, rdata[d], err[d]);
          end else begin
            mon_e = sb_q.pop_front();
            if (int'(mon_e.dut) != d || rdata[d] !== mon_e.dat || err[d] !== mon_e.err) begin
              failures++;
              $display("FAIL resp dut%0d: got data=%h err=%b, expected dut%0d data=%h err=%b",
                       d, rdata[d], err[d], mon_e.dut, mon_e.dat, mon_e.err);
            end
            checks++;
            if (cyc != mon_e.due) begin
              failures++;
              $display("FAIL latency dut%0d: got rvalid at cycle %0d, expected cycle %0d", d, cyc, mon_e.due);
            end
          end
        end
      end
    end
  end

  task automatic dcheck(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    dq_nm.push_back(nm);
    dq_act.push_back(act);
    dq_exp.push_back(exp_v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      dcheck("resp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Issue one request on dut d, push its expected response, wait for it.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un, input logic e_err, input logic [31:0] e_dat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) dcheck("ready_timeout", 32'(n), 32'd0);
    we[d] = w; addr[d] = a; wdata[d] = wd; size[d] = sz; uns[d] = un; req[d] = 1'b1;
    @(posedge clk);
    #1;
    e.dut = 2'(d);
    e.err = e_err;
    e.dat = e_dat;
    e.due = cyc + (e_err ? 0 : ws_of(d));
    sb_q.push_back(e);
    req[d] = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int   accepts;
  logic r_rdy;

  initial begin
    rst_n = '0; req = '0; we = '0; uns = '0; addr = '0; wdata = '0; size = '0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      dcheck($sformatf("reset_ready%0d", d),  32'(ready[d]),  32'd1);
      dcheck($sformatf("reset_rvalid%0d", d), 32'(rvalid[d]), 32'd0);
      dcheck($sformatf("reset_rdata%0d", d),  rdata[d],       32'd0);
      dcheck($sformatf("reset_err%0d", d),    32'(err[d]),    32'd0);
    end

    // WAIT_STATES = 1: word, byte and half traffic.
    issue(0, 1, B + 4, 32'hDEADBEEF, SZ_WORD, 0, 0, 32'h0);
    issue(0, 0, B + 4, 32'h0,        SZ_WORD, 0, 0, 32'hDEADBEEF);
    issue(0, 1, B + 7, 32'h12345680, SZ_BYTE, 0, 0, 32'h0);
    issue(0, 0, B + 4, 32'h0,        SZ_WORD, 0, 0, 32'h80ADBEEF);
    issue(0, 0, B + 7, 32'h0,        SZ_BYTE, 0, 0, 32'hFFFFFF80);
    issue(0, 0, B + 7, 32'h0,        SZ_BYTE, 1, 0, 32'h00000080);
    issue(0, 0, B + 6, 32'h0,        SZ_HALF, 1, 0, 32'h000080AD);
    issue(0, 0, B + 6, 32'h0,        SZ_HALF, 0, 0, 32'hFFFF80AD);
    issue(0, 0, B + 4, 32'h0,        SZ_BYTE, 0, 0, 32'hFFFFFFEF);
    issue(0, 0, B + 4, 32'h0,        SZ_HALF, 1, 0, 32'h0000BEEF);
    issue(0, 0, B + 5, 32'h0,        SZ_BYTE, 1, 0, 32'h000000BE);
    issue(0, 1, B + 4, 32'hFFFF1234, SZ_HALF, 0, 0, 32'h0);
    issue(0, 0, B + 4, 32'h0,        SZ_WORD, 0, 0, 32'h80AD1234);
    issue(0, 1, B,     32'h0BADCAFE, SZ_WORD, 0, 0, 32'h0);

    // Rejected accesses: all respond after one cycle with oErr and zero data.
    issue(0, 0, B + 2,       32'h0,        SZ_WORD, 0, 1, 32'h0);
    issue(0, 1, B + 1,       32'h00005555, SZ_HALF, 0, 1, 32'h0);
    issue(0, 0, B + 1024,    32'h0,        SZ_WORD, 0, 1, 32'h0);
    issue(0, 1, B + 1024,    32'hFFFFFFFF, SZ_WORD, 0, 1, 32'h0);
    issue(0, 1, B + 4,       32'hFFFFFFFF, SZ_ILL,  0, 1, 32'h0);
    issue(0, 0, B + 4,       32'h0,        SZ_ILL,  0, 1, 32'h0);
    issue(0, 1, B - 32'd4,   32'hFFFFFFFF, SZ_WORD, 0, 1, 32'h0);
    issue(0, 0, B,           32'h0,        SZ_WORD, 0, 0, 32'h0BADCAFE);
    issue(0, 0, B + 4,       32'h0,        SZ_WORD, 0, 0, 32'h80AD1234);

    // WAIT_STATES = 2: iReq held for 10 cycles, accepts every 4th cycle.
    issue(1, 1, B + 8, 32'h55AA1234, SZ_WORD, 0, 0, 32'h0);
    @(negedge clk);
    we[1] = 1'b0; addr[1] = B + 8; size[1] = SZ_WORD; uns[1] = 1'b0; req[1] = 1'b1;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      r_rdy = ready[1];
      dcheck($sformatf("busy_ready_k%0d", k), 32'(r_rdy), (k % 4 == 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      if (r_rdy === 1'b1) begin
        accepts++;
        sb_q.push_back('{dut: 2'd1, err: 1'b0, dat: 32'h55AA1234, due: cyc + 2});
      end
      @(negedge clk);
    end
    req[1] = 1'b0;
    dcheck("busy_accepts", 32'(accepts), 32'd3);
    drain();

    // WAIT_STATES = 3: reset during the second WAIT cycle drops the store.
    issue(2, 1, B, 32'hCAFEF00D, SZ_WORD, 0, 0, 32'h0);
    @(negedge clk);
    we[2] = 1'b1; addr[2] = B; wdata[2] = 32'h12345678; size[2] = SZ_WORD; uns[2] = 1'b0; req[2] = 1'b1;
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    dcheck("rst_wait_ready_w1", 32'(ready[2]), 32'd0);
    @(posedge clk);
    #2;
    rst_n[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (6) @(negedge clk);
    dcheck("rst_wait_ready", 32'(ready[2]), 32'd1);
    dcheck("rst_wait_rdata", rdata[2],      32'd0);
    dcheck("rst_wait_err",   32'(err[2]),   32'd0);
    issue(2, 0, B, 32'h0, SZ_WORD, 0, 0, 32'hCAFEF00D);

    // WAIT_STATES = 0 at the top word of the RAM.
    issue(3, 1, B + 32'h3FC, 32'hA5A55A5A, SZ_WORD, 0, 0, 32'h0);
    issue(3, 0, B + 32'h3FC, 32'h0,        SZ_WORD, 0, 0, 32'hA5A55A5A);
    issue(3, 1, B + 32'h3FD, 32'h0000007F, SZ_BYTE, 0, 0, 32'h0);
    issue(3, 0, B + 32'h3FC, 32'h0,        SZ_HALF, 0, 0, 32'h00007F5A);
    issue(3, 0, B + 32'h3FE, 32'h0,        SZ_BYTE, 0, 0, 32'hFFFFFFA5);
    issue(3, 0, B + 32'h3FC, 32'h0,        SZ_WORD, 0, 0, 32'hA5A57F5A);
    issue(3, 0, B + 32'h400, 32'h0,        SZ_WORD, 0, 1, 32'h0);

    repeat (3) @(negedge clk);
    dcheck("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
